// File: rtl/rr_valid_ready_arb.sv
// rr_valid_ready_arb
//
// Round-robin arbiter that merges NUM_REQ upstream valid/ready requesters
// onto one downstream valid/ready channel. The output is a single fully
// registered slot. With ready_down held high it moves one word per cycle.
//
// Ports:
//   sys_clk     - single clock, all state updates on the rising edge
//   sys_rst_n   - asynchronous assert, active-low reset
//   valid_up    - per-requester valid
//   data_up     - packed payloads; requester i owns [i*DATA_W +: DATA_W]
//   ready_up    - per-requester ready (combinational, one-hot or zero)
//   valid_down  - registered output valid
//   data_down   - registered output payload
//   grant_id    - registered index of the requester whose word is in data_down
//   ready_down  - downstream ready
//
// ID_W must equal ceil(log2(NUM_REQ)).

module rr_valid_ready_arb #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 3,
    parameter int ID_W    = 2
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic [NUM_REQ-1:0]        valid_up,
    input  logic [NUM_REQ*DATA_W-1:0] data_up,
    output logic [NUM_REQ-1:0]        ready_up,
    output logic                      valid_down,
    output logic [DATA_W-1:0]         data_down,
    output logic [ID_W-1:0]           grant_id,
    input  logic                      ready_down
);

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   next_ptr;
    logic [DATA_W-1:0] winner_data;
    logic              any_req;
    logic              load_en;
    logic              found;
    int                idx;

    // The slot can take a new word when it is empty or is being drained
    // in this same cycle. This is the only path from ready_down to
    // ready_up. ready_down never reaches the slot registers combinationally.
    assign load_en = !valid_down || ready_down;
    assign any_req = |valid_up;

    // Scan the requesters starting at rr_ptr and wrap modulo NUM_REQ.
    // The index is folded back explicitly because NUM_REQ need not be a
    // power of two. The first valid requester found wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && valid_up[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    assign winner_data = data_up[int'(winner)*DATA_W +: DATA_W];

    // The pointer moves past the winner so that the winner becomes the
    // lowest priority next time. The wrap happens at NUM_REQ, not at 2^ID_W.
    always_comb begin
        if (int'(winner) == NUM_REQ - 1) begin
            next_ptr = '0;
        end else begin
            next_ptr = winner + ID_W'(1);
        end
    end

    // Only the winner sees ready, and only when the slot can accept a word.
    // Payload data never affects ready.
    always_comb begin
        ready_up = '0;
        if (load_en && any_req) begin
            ready_up[winner] = 1'b1;
        end
    end

    // Output slot and rotation pointer. A load overwrites a draining word
    // on the same edge, so back-to-back transfers leave no bubble. When the
    // slot is stalled (full and ready_down low), everything holds.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            valid_down <= 1'b0;
            data_down  <= '0;
            grant_id   <= '0;
            rr_ptr     <= '0;
        end else if (load_en) begin
            if (any_req) begin
                valid_down <= 1'b1;
                data_down  <= winner_data;
                grant_id   <= winner;
                rr_ptr     <= next_ptr;
            end else begin
                valid_down <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_valid_ready_arb.sv
// tb_rr_valid_ready_arb
//
// Directed testbench for rr_valid_ready_arb with NUM_REQ=4, DATA_W=3.
// Requester i always presents payload i+1. Inputs are driven just after
// the falling edge. Outputs and the combinational ready_up are sampled
// away from the rising edge.

module tb_rr_valid_ready_arb;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 3;
    localparam int ID_W    = 2;

    logic                      sys_clk;
    logic                      sys_rst_n;
    logic [NUM_REQ-1:0]        valid_up;
    logic [NUM_REQ*DATA_W-1:0] data_up;
    logic [NUM_REQ-1:0]        ready_up;
    logic                      valid_down;
    logic [DATA_W-1:0]         data_down;
    logic [ID_W-1:0]           grant_id;
    logic                      ready_down;

    int checks;
    int errors;

    rr_valid_ready_arb #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .ID_W    (ID_W)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .valid_up   (valid_up),
        .data_up    (data_up),
        .ready_up   (ready_up),
        .valid_down (valid_down),
        .data_down  (data_down),
        .grant_id   (grant_id),
        .ready_down (ready_down)
    );

    // 10 ns clock: rising edges at 5, 15, 25, ...
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Reset held for three cycles with no requests. Everything must read zero.
    task automatic test_reset();
        sys_rst_n  = 1'b0;
        valid_up   = '0;
        ready_down = 1'b1;
        data_up    = {3'd4, 3'd3, 3'd2, 3'd1};
        for (int c = 0; c < 3; c++) begin
            @(negedge sys_clk);
            #1;
            checks++;
            if (valid_down !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_valid cyc%0d: got %0b expected 0", c, valid_down);
            end
            checks++;
            if (data_down !== 3'd0) begin
                errors++;
                $display("[TB] FAIL reset_data cyc%0d: got %0d expected 0", c, data_down);
            end
            checks++;
            if (grant_id !== 2'd0) begin
                errors++;
                $display("[TB] FAIL reset_grant cyc%0d: got %0d expected 0", c, grant_id);
            end
            checks++;
            if (ready_up !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL reset_ready_up cyc%0d: got %b expected 0000", c, ready_up);
            end
        end
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        #1;
        checks++;
        if (valid_down !== 1'b0 || ready_up !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got valid=%0b ready_up=%b expected 0/0000",
                     valid_down, ready_up);
        end
    endtask

    // All four requesters valid with downstream always ready. Grants rotate
    // 0,1,2,3,0,1,2,3 and valid_down stays high the whole time.
    task automatic test_round_robin();
        logic [3:0] exp_ready;
        valid_up   = 4'b1111;
        ready_down = 1'b1;
        #1;
        checks++;
        if (ready_up !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL rr_first_ready: got %b expected 0001", ready_up);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge sys_clk);
            #1;
            exp_ready = 4'b0001 << ((i + 1) % 4);
            checks++;
            if (valid_down !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rr_valid[%0d]: got %0b expected 1", i, valid_down);
            end
            checks++;
            if (grant_id !== 2'(i % 4)) begin
                errors++;
                $display("[TB] FAIL rr_grant[%0d]: got %0d expected %0d", i, grant_id, i % 4);
            end
            checks++;
            if (data_down !== 3'((i % 4) + 1)) begin
                errors++;
                $display("[TB] FAIL rr_data[%0d]: got %0d expected %0d", i, data_down, (i % 4) + 1);
            end
            checks++;
            if (ready_up !== exp_ready) begin
                errors++;
                $display("[TB] FAIL rr_ready_up[%0d]: got %b expected %b", i, ready_up, exp_ready);
            end
        end
        valid_up = 4'b0000;
        @(negedge sys_clk);
        #1;
        checks++;
        if (valid_down !== 1'b0 || grant_id !== 2'd3 || data_down !== 3'd4) begin
            errors++;
            $display("[TB] FAIL rr_drain_hold: got v=%0b g=%0d d=%0d expected v=0 g=3 d=4",
                     valid_down, grant_id, data_down);
        end
    endtask

    // One word loaded, then downstream stalls for five cycles with everyone
    // requesting. The slot freezes and no one gets ready. On release, the next
    // requester in rotation (1) is accepted in that same cycle.
    task automatic test_backpressure();
        valid_up   = 4'b1111;
        ready_down = 1'b0;
        #1;
        checks++;
        if (ready_up !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL bp_load_ready: got %b expected 0001", ready_up);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge sys_clk);
            #1;
            checks++;
            if (ready_up !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL bp_ready_up cyc%0d: got %b expected 0000", c, ready_up);
            end
            checks++;
            if (valid_down !== 1'b1 || grant_id !== 2'd0 || data_down !== 3'd1) begin
                errors++;
                $display("[TB] FAIL bp_frozen cyc%0d: got v=%0b g=%0d d=%0d expected v=1 g=0 d=1",
                         c, valid_down, grant_id, data_down);
            end
        end
        ready_down = 1'b1;
        #1;
        checks++;
        if (ready_up !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL bp_release_ready: got %b expected 0010", ready_up);
        end
        @(negedge sys_clk);
        #1;
        checks++;
        if (valid_down !== 1'b1 || grant_id !== 2'd1 || data_down !== 3'd2) begin
            errors++;
            $display("[TB] FAIL bp_after_release: got v=%0b g=%0d d=%0d expected v=1 g=1 d=2",
                     valid_down, grant_id, data_down);
        end
        valid_up = 4'b0000;
        @(negedge sys_clk);
    endtask

    // Pointer is 2 on entry. Requester 2 wins (pointer becomes 3), then with
    // 0 and 2 requesting the scan wraps to 0, then returns to 2.
    task automatic test_rotation();
        valid_up = 4'b0100;
        #1;
        checks++;
        if (ready_up !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL rot_ready_2: got %b expected 0100", ready_up);
        end
        @(negedge sys_clk);
        valid_up = 4'b0101;
        #1;
        checks++;
        if (grant_id !== 2'd2 || data_down !== 3'd3) begin
            errors++;
            $display("[TB] FAIL rot_grant_2: got g=%0d d=%0d expected g=2 d=3", grant_id, data_down);
        end
        checks++;
        if (ready_up !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL rot_wrap_ready: got %b expected 0001", ready_up);
        end
        @(negedge sys_clk);
        valid_up = 4'b0100;
        #1;
        checks++;
        if (grant_id !== 2'd0 || data_down !== 3'd1) begin
            errors++;
            $display("[TB] FAIL rot_grant_0: got g=%0d d=%0d expected g=0 d=1", grant_id, data_down);
        end
        checks++;
        if (ready_up !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL rot_ready_2b: got %b expected 0100", ready_up);
        end
        @(negedge sys_clk);
        valid_up = 4'b0000;
        #1;
        checks++;
        if (valid_down !== 1'b1 || grant_id !== 2'd2 || data_down !== 3'd3) begin
            errors++;
            $display("[TB] FAIL rot_grant_2b: got v=%0b g=%0d d=%0d expected v=1 g=2 d=3",
                     valid_down, grant_id, data_down);
        end
        @(negedge sys_clk);
        #1;
        checks++;
        if (valid_down !== 1'b0 || grant_id !== 2'd2) begin
            errors++;
            $display("[TB] FAIL rot_idle_hold: got v=%0b g=%0d expected v=0 g=2", valid_down, grant_id);
        end
    endtask

    // Pointer is 3 on entry. A lone requester 0 is granted despite the
    // pointer. Requester 1 is then loaded while that word drains, with no idle gap.
    task automatic test_back_to_back();
        valid_up = 4'b0001;
        #1;
        checks++;
        if (ready_up !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL b2b_single_ready: got %b expected 0001", ready_up);
        end
        @(negedge sys_clk);
        valid_up   = 4'b0010;
        ready_down = 1'b1;
        #1;
        checks++;
        if (valid_down !== 1'b1 || grant_id !== 2'd0) begin
            errors++;
            $display("[TB] FAIL b2b_first: got v=%0b g=%0d expected v=1 g=0", valid_down, grant_id);
        end
        checks++;
        if (ready_up !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL b2b_ready_1: got %b expected 0010", ready_up);
        end
        @(negedge sys_clk);
        valid_up = 4'b0000;
        #1;
        checks++;
        if (valid_down !== 1'b1 || grant_id !== 2'd1 || data_down !== 3'd2) begin
            errors++;
            $display("[TB] FAIL b2b_second: got v=%0b g=%0d d=%0d expected v=1 g=1 d=2",
                     valid_down, grant_id, data_down);
        end
        @(negedge sys_clk);
    endtask

    // Pointer is 2 on entry. Requester 1 is loaded, which leaves the pointer
    // at 2. Reset then asserts between clock edges. The slot clears at once,
    // and after release the pointer is back at 0, so requester 1 wins over 2.
    task automatic test_async_reset();
        valid_up = 4'b0010;
        @(negedge sys_clk);
        valid_up = 4'b0000;
        #1;
        checks++;
        if (valid_down !== 1'b1 || grant_id !== 2'd1) begin
            errors++;
            $display("[TB] FAIL ar_loaded: got v=%0b g=%0d expected v=1 g=1", valid_down, grant_id);
        end
        #1;
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if (valid_down !== 1'b0 || data_down !== 3'd0 || grant_id !== 2'd0) begin
            errors++;
            $display("[TB] FAIL ar_immediate: got v=%0b d=%0d g=%0d expected 0/0/0",
                     valid_down, data_down, grant_id);
        end
        valid_up = 4'b0110;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        #1;
        checks++;
        if (valid_down !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ar_held: got v=%0b expected 0", valid_down);
        end
        checks++;
        if (ready_up !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL ar_first_ready: got %b expected 0010", ready_up);
        end
        @(negedge sys_clk);
        valid_up = 4'b0100;
        #1;
        checks++;
        if (valid_down !== 1'b1 || grant_id !== 2'd1 || data_down !== 3'd2) begin
            errors++;
            $display("[TB] FAIL ar_first_grant: got v=%0b g=%0d d=%0d expected v=1 g=1 d=2",
                     valid_down, grant_id, data_down);
        end
        @(negedge sys_clk);
        valid_up = 4'b0000;
        #1;
        checks++;
        if (grant_id !== 2'd2 || data_down !== 3'd3) begin
            errors++;
            $display("[TB] FAIL ar_second_grant: got g=%0d d=%0d expected g=2 d=3", grant_id, data_down);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_rotation();
        test_back_to_back();
        test_async_reset();
        @(negedge sys_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
